// File: rtl/flit_pkg.sv
// Shared constants and types for the local-port flit download path.
package flit_pkg;

   localparam int FLIT_CTRL_W = 2;

   localparam logic [FLIT_CTRL_W-1:0] CTRL_HEAD = 2'b01;
   localparam logic [FLIT_CTRL_W-1:0] CTRL_BODY = 2'b10;
   localparam logic [FLIT_CTRL_W-1:0] CTRL_TAIL = 2'b11;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} dl_state_t;

endpackage

// File: rtl/flit_rr_arbiter.sv
// Combinational channel arbiter: fixed priority (lowest index) or round-robin
// search starting at ptr.
module flit_rr_arbiter #(
   parameter  int NCH   = 2,
   parameter  int RR_EN = 0,
   localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [IW-1:0]  idx
);

   int unsigned i;
   logic        found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      i     = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         i = (RR_EN != 0) ? ((k + 32'(ptr)) % NCH) : k;
         if (!found && req[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            idx    = IW'(i);
         end
      end
   end

endmodule

// File: rtl/flit_download_arbiter.sv
// Local-port download controller: grants one eligible channel, loads its
// message flit by flit into a register file and holds it until acknowledged.
module flit_download_arbiter
   import flit_pkg::*;
#(
   parameter  int FLIT_W    = 16,
   parameter  int NCH       = 2,
   parameter  int MAX_FLITS = 11,
   parameter  int DEST_BIT  = 13,
   parameter  int RR_EN     = 0,
   localparam int FW        = FLIT_W + FLIT_CTRL_W,
   localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int LW        = $clog2(MAX_FLITS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NCH*FW-1:0]           in_flit,
   input  logic [NCH-1:0]              in_rdy,
   input  logic                        msg_ack,
   output logic [NCH-1:0]              en_deq,
   output logic                        msg_rdy,
   output logic [CW-1:0]               msg_ch,
   output logic [LW-1:0]               msg_len,
   output logic [MAX_FLITS*FLIT_W-1:0] msg_data,
   output logic                        err_ovf
);

   dl_state_t         state;
   logic [CW-1:0]     rr_ptr;
   logic [LW-1:0]     cnt;
   logic [FLIT_W-1:0] mem [MAX_FLITS];

   logic [NCH-1:0]         elig;
   logic [NCH-1:0]         gnt_oh;
   logic [CW-1:0]          gnt_idx;
   logic [CW-1:0]          ptr_next;
   logic [FW-1:0]          cur;
   logic [FLIT_CTRL_W-1:0] cur_ctrl;
   logic                   cur_rdy;

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         elig[i] = in_rdy[i]
                 && (in_flit[i*FW+FLIT_W +: FLIT_CTRL_W] == CTRL_HEAD)
                 && !in_flit[i*FW+DEST_BIT];
      end
   end

   flit_rr_arbiter #(.NCH(NCH), .RR_EN(RR_EN)) u_arb (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (gnt_oh),
      .idx (gnt_idx)
   );

   assign ptr_next = (gnt_idx == CW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

   // msg_ch doubles as the registered grant for the whole message.
   always_comb begin
      cur     = '0;
      cur_rdy = 1'b0;
      en_deq  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (CW'(i) == msg_ch) begin
            cur     = in_flit[i*FW +: FW];
            cur_rdy = in_rdy[i];
            if (state == LOAD || state == DRAIN) en_deq[i] = in_rdy[i];
         end
      end
      cur_ctrl = cur[FW-1 -: FLIT_CTRL_W];
   end

   for (genvar k = 0; k < MAX_FLITS; k++) begin : g_out
      assign msg_data[k*FLIT_W +: FLIT_W] = mem[k];
   end

   always_ff @(posedge clk) begin
      err_ovf <= 1'b0;
      if (!rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         cnt     <= '0;
         msg_rdy <= 1'b0;
         msg_ch  <= '0;
         msg_len <= '0;
         for (int unsigned k = 0; k < MAX_FLITS; k++) mem[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|gnt_oh) begin
                  msg_ch <= gnt_idx;
                  if (RR_EN != 0) rr_ptr <= ptr_next;
                  cnt    <= '0;
                  for (int unsigned k = 0; k < MAX_FLITS; k++) mem[k] <= '0;
                  state  <= LOAD;
               end
            end
            LOAD: begin
               if (cur_rdy) begin
                  for (int unsigned k = 0; k < MAX_FLITS; k++) begin
                     if (cnt == LW'(k)) mem[k] <= cur[FLIT_W-1:0];
                  end
                  cnt <= cnt + 1'b1;
                  if (cur_ctrl == CTRL_TAIL) begin
                     msg_len <= cnt + 1'b1;
                     msg_rdy <= 1'b1;
                     state   <= HOLD;
                  end else if (cnt == LW'(MAX_FLITS - 1)) begin
                     err_ovf <= 1'b1;
                     state   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (cur_rdy && cur_ctrl == CTRL_TAIL) state <= IDLE;
            end
            HOLD: begin
               if (msg_ack) begin
                  msg_rdy <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flit_download_arbiter.sv
// Directed bench: three arbiter configurations fed from bench-side FIFO models.
module tb_flit_download_arbiter;

   localparam int FW = 18;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // global FIFO index: 0-1 dut_a, 2-5 dut_r, 6-7 dut_o
   logic [FW-1:0] fm [8][64];
   int            rp [8];
   int            wp [8];
   int            deq [8];
   logic          gap [8];
   logic          flush [8];
   logic [8*FW-1:0] flit_cat;
   logic [7:0]      rdy_cat;
   logic [7:0]      en_cat;
   int              oh_err;

   logic         msg_ack_a, msg_ack_r, msg_ack_o;
   logic [1:0]   en_a;
   logic [3:0]   en_r;
   logic [1:0]   en_o;
   logic         msg_rdy_a, msg_rdy_r, msg_rdy_o;
   logic [0:0]   msg_ch_a, msg_ch_o;
   logic [1:0]   msg_ch_r;
   logic [3:0]   msg_len_a, msg_len_r;
   logic [2:0]   msg_len_o;
   logic [175:0] msg_data_a, msg_data_r;
   logic [63:0]  msg_data_o;
   logic         err_a, err_r, err_o;

   int n_cmp = 0;
   int n_err = 0;

   assign en_cat = {en_o, en_r, en_a};

   always_comb begin
      flit_cat = '0;
      rdy_cat  = '0;
      for (int g = 0; g < 8; g++) begin
         if (rp[g] != wp[g]) flit_cat[g*FW +: FW] = fm[g][rp[g] % 64];
         rdy_cat[g] = (rp[g] != wp[g]) && !gap[g];
      end
   end

   always @(posedge clk) begin
      for (int g = 0; g < 8; g++) begin
         if (flush[g] === 1'b1) rp[g] <= wp[g];
         else if (en_cat[g] === 1'b1) begin
            rp[g]  <= rp[g] + 1;
            deq[g] <= deq[g] + 1;
         end
      end
      if ($countones(en_a) > 1 || $countones(en_r) > 1 || $countones(en_o) > 1)
         oh_err <= oh_err + 1;
   end

   flit_download_arbiter #(.FLIT_W(16), .NCH(2), .MAX_FLITS(11), .DEST_BIT(13), .RR_EN(0)) dut_a (
      .clk(clk), .rst(rst), .in_flit(flit_cat[0 +: 2*FW]), .in_rdy(rdy_cat[1:0]),
      .msg_ack(msg_ack_a), .en_deq(en_a), .msg_rdy(msg_rdy_a), .msg_ch(msg_ch_a),
      .msg_len(msg_len_a), .msg_data(msg_data_a), .err_ovf(err_a));

   flit_download_arbiter #(.FLIT_W(16), .NCH(4), .MAX_FLITS(11), .DEST_BIT(13), .RR_EN(1)) dut_r (
      .clk(clk), .rst(rst), .in_flit(flit_cat[2*FW +: 4*FW]), .in_rdy(rdy_cat[5:2]),
      .msg_ack(msg_ack_r), .en_deq(en_r), .msg_rdy(msg_rdy_r), .msg_ch(msg_ch_r),
      .msg_len(msg_len_r), .msg_data(msg_data_r), .err_ovf(err_r));

   flit_download_arbiter #(.FLIT_W(16), .NCH(2), .MAX_FLITS(4), .DEST_BIT(13), .RR_EN(0)) dut_o (
      .clk(clk), .rst(rst), .in_flit(flit_cat[6*FW +: 2*FW]), .in_rdy(rdy_cat[7:6]),
      .msg_ack(msg_ack_o), .en_deq(en_o), .msg_rdy(msg_rdy_o), .msg_ch(msg_ch_o),
      .msg_len(msg_len_o), .msg_data(msg_data_o), .err_ovf(err_o));

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pay(input int m, input int k);
      return 16'((m << 8) | k);
   endfunction

   function automatic logic [255:0] exp_data(input int m, input int n);
      logic [255:0] v = '0;
      for (int k = 0; k < n; k++) v[k*16 +: 16] = pay(m, k);
      return v;
   endfunction

   task automatic send(input int ch, input int m, input int n, input logic far);
      fm[ch][wp[ch] % 64] = {2'b01, pay(m, 0) | (far ? 16'h2000 : 16'h0000)};
      wp[ch]++;
      for (int k = 1; k < n - 1; k++) begin
         fm[ch][wp[ch] % 64] = {2'b10, pay(m, k)};
         wp[ch]++;
      end
      fm[ch][wp[ch] % 64] = {2'b11, pay(m, n - 1)};
      wp[ch]++;
   endtask

   function automatic logic rdy_of(input int w);
      case (w)
         0:       return msg_rdy_a;
         1:       return msg_rdy_r;
         default: return msg_rdy_o;
      endcase
   endfunction

   task automatic wait_rdy(input string tag, input int w, input int limit);
      int cyc = 0;
      while (rdy_of(w) !== 1'b1 && cyc < limit) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, " msg_rdy within bound"}, 256'(rdy_of(w)), 256'd1);
   endtask

   task automatic ack(input int w);
      case (w)
         0:       msg_ack_a = 1'b1;
         1:       msg_ack_r = 1'b1;
         default: msg_ack_o = 1'b1;
      endcase
      @(negedge clk);
      msg_ack_a = 1'b0;
      msg_ack_r = 1'b0;
      msg_ack_o = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_ovf, n_rdy, d0;
      int exp_ch [5];
      int exp_m  [5];

      rst = 1'b0;
      msg_ack_a = 1'b0; msg_ack_r = 1'b0; msg_ack_o = 1'b0;
      for (int g = 0; g < 8; g++) begin
         gap[g] = 1'b0;
         flush[g] = 1'b0;
      end
      repeat (2) @(negedge clk);

      chk("rst en_deq",   256'(en_a),       256'd0);
      chk("rst msg_rdy",  256'(msg_rdy_a),  256'd0);
      chk("rst msg_ch",   256'(msg_ch_a),   256'd0);
      chk("rst msg_len",  256'(msg_len_a),  256'd0);
      chk("rst msg_data", 256'(msg_data_a), 256'd0);
      chk("rst err_ovf",  256'(err_a),      256'd0);
      chk("rst rr msg_rdy",  256'(msg_rdy_r), 256'd0);
      chk("rst ovf msg_rdy", 256'(msg_rdy_o), 256'd0);
      rst = 1'b1;
      @(negedge clk);

      // 11-flit message on req channel, grant cycle is the current one
      send(1, 1, 11, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         chk($sformatf("t1 en_deq c%0d", c), 256'(en_a), 256'd2);
      end
      chk("t1 msg_rdy low before tail", 256'(msg_rdy_a), 256'd0);
      @(negedge clk);
      chk("t1 msg_rdy at grant+12", 256'(msg_rdy_a), 256'd1);
      chk("t1 en_deq idle in hold",  256'(en_a),      256'd0);
      chk("t1 msg_len",  256'(msg_len_a),  256'd11);
      chk("t1 msg_ch",   256'(msg_ch_a),   256'd1);
      chk("t1 msg_data", 256'(msg_data_a), exp_data(1, 11));
      chk("t1 dequeue count", 256'(deq[1]), 256'd11);
      @(negedge clk);
      chk("t1 msg_rdy held", 256'(msg_rdy_a), 256'd1);
      ack(0);
      chk("t1 msg_rdy after ack", 256'(msg_rdy_a), 256'd0);

      // simultaneous heads, fixed priority
      send(0, 2, 3, 1'b0);
      send(1, 3, 3, 1'b0);
      wait_rdy("t2 first", 0, 10);
      chk("t2 first msg_ch",   256'(msg_ch_a),   256'd0);
      chk("t2 first msg_data", 256'(msg_data_a), exp_data(2, 3));
      chk("t2 ch1 untouched",  256'(deq[1]),     256'd11);
      ack(0);
      chk("t2 idle cycle en_deq", 256'(en_a), 256'd0);
      @(negedge clk);
      chk("t2 ch1 head in first LOAD", 256'(en_a), 256'd2);
      wait_rdy("t2 second", 0, 10);
      chk("t2 second msg_ch",   256'(msg_ch_a),   256'd1);
      chk("t2 second msg_data", 256'(msg_data_a), exp_data(3, 3));
      ack(0);

      // bubble: in_rdy low for three cycles after the head
      send(0, 4, 5, 1'b0);
      @(negedge clk);
      chk("t3 head en_deq", 256'(en_a), 256'd1);
      @(negedge clk);
      chk("t3 body1 presented", 256'(en_a), 256'd1);
      gap[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t3 gap en_deq c%0d", c), 256'(en_a), 256'd0);
      end
      gap[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("t3 resume en_deq c%0d", c), 256'(en_a), 256'd1);
      end
      @(negedge clk);
      chk("t3 msg_rdy",  256'(msg_rdy_a),  256'd1);
      chk("t3 msg_len",  256'(msg_len_a),  256'd5);
      chk("t3 msg_data", 256'(msg_data_a), exp_data(4, 5));
      ack(0);

      // overflow: 6 flits into a 4-deep register file
      send(6, 5, 6, 1'b0);
      n_ovf = 0;
      n_rdy = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (err_o === 1'b1) n_ovf++;
         if (msg_rdy_o === 1'b1) n_rdy++;
         if (c == 5) chk("t4 err_ovf timing", 256'(err_o), 256'd1);
      end
      chk("t4 err_ovf pulse count", 256'(n_ovf),   256'd1);
      chk("t4 msg_rdy never",       256'(n_rdy),   256'd0);
      chk("t4 all flits dequeued",  256'(deq[6]),  256'd6);
      chk("t4 en_deq idle",         256'(en_o),    256'd0);
      send(6, 9, 4, 1'b0);
      wait_rdy("t4 full-depth", 2, 12);
      chk("t4 full-depth msg_len",  256'(msg_len_o),  256'd4);
      chk("t4 full-depth msg_data", 256'(msg_data_o), exp_data(9, 4));
      chk("t4 full-depth no ovf",   256'(err_o),      256'd0);
      ack(2);

      // round-robin, four channels plus a second message on channel 0
      send(2, 10, 3, 1'b0);
      send(3, 11, 3, 1'b0);
      send(4, 12, 3, 1'b0);
      send(5, 13, 3, 1'b0);
      send(2, 14, 3, 1'b0);
      exp_ch = '{0, 1, 2, 3, 0};
      exp_m  = '{10, 11, 12, 13, 14};
      for (int j = 0; j < 5; j++) begin
         wait_rdy($sformatf("t5 grant%0d", j), 1, 12);
         chk($sformatf("t5 grant%0d msg_ch", j),   256'(msg_ch_r),   256'(exp_ch[j]));
         chk($sformatf("t5 grant%0d msg_data", j), 256'(msg_data_r), exp_data(exp_m[j], 3));
         ack(1);
      end
      chk("t5 ch0 dequeues", 256'(deq[2]), 256'd6);
      chk("t5 ch3 dequeues", 256'(deq[5]), 256'd3);

      // reset mid-LOAD, then a clean message and a remote-bound head
      send(1, 6, 6, 1'b0);
      @(negedge clk);
      chk("t6 head en_deq", 256'(en_a), 256'd2);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6 rst en_deq",   256'(en_a),       256'd0);
      chk("t6 rst msg_rdy",  256'(msg_rdy_a),  256'd0);
      chk("t6 rst msg_ch",   256'(msg_ch_a),   256'd0);
      chk("t6 rst msg_len",  256'(msg_len_a),  256'd0);
      chk("t6 rst msg_data", 256'(msg_data_a), 256'd0);
      chk("t6 rst err_ovf",  256'(err_a),      256'd0);
      flush[1] = 1'b1;
      @(negedge clk);
      flush[1] = 1'b0;
      d0 = deq[0];
      send(0, 7, 3, 1'b1);
      send(1, 8, 3, 1'b0);
      wait_rdy("t6 clean", 0, 12);
      chk("t6 clean msg_ch",   256'(msg_ch_a),   256'd1);
      chk("t6 clean msg_len",  256'(msg_len_a),  256'd3);
      chk("t6 clean msg_data", 256'(msg_data_a), exp_data(8, 3));
      ack(0);
      repeat (5) @(negedge clk);
      chk("t6 remote head not granted", 256'(deq[0]),    256'(d0));
      chk("t6 remote head no msg",      256'(msg_rdy_a), 256'd0);

      chk("en_deq one-hot", 256'(oh_err), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
